// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback merge stage.
//   - Default parameter constants for the lane datapath.
//   - wb_entry_t: one register-file write (index, lane data, lane mask) at default widths.
//   - mask_is_zero: true when no lane would be written.
package wb_pkg;

    localparam int unsigned LANES_DEF      = 4;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned IDX_WIDTH_DEF  = 4;
    localparam int unsigned DEPTH_DEF      = 4;

    // Widest mask the helper accepts; callers zero-extend narrower masks.
    localparam int unsigned MASK_MAX = 32;

    typedef struct packed {
        logic [IDX_WIDTH_DEF-1:0]                idx;
        logic [LANES_DEF*DATA_WIDTH_DEF-1:0]     data;
        logic [LANES_DEF-1:0]                    mask;
    } wb_entry_t;

    function automatic logic mask_is_zero(input logic [MASK_MAX-1:0] mask);
        return (mask == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding results that could not be written in their own cycle.
// Up to two pushes and one pop per cycle; pointers wrap modulo DEPTH (any DEPTH >= 2).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_flush       synchronous clear of pointers and occupancy
//   i_push0/1     push enables with data; i_push1 is only used together with i_push0
//   i_pop         remove the head entry
//   o_head        current head entry (valid when o_count != 0)
//   o_count       current occupancy
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push0,
    input  logic [WIDTH-1:0] i_data0,
    input  logic             i_push1,
    input  logic [WIDTH-1:0] i_data1,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CntW-1:0]  o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [CntW-1:0]  r_count;
    logic [PtrW-1:0]  w_wr_ptr_p1;
    logic [CntW-1:0]  w_count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign w_wr_ptr_p1 = ptr_inc(r_wr_ptr);
    assign w_count_d   = r_count + CntW'(i_push0) + CntW'(i_push1) - CntW'(i_pop);
    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push1) begin
                r_wr_ptr <= ptr_inc(w_wr_ptr_p1);
            end else if (i_push0) begin
                r_wr_ptr <= w_wr_ptr_p1;
            end
            r_count <= w_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_data0;
        end
        if (i_push1) begin
            r_mem[w_wr_ptr_p1] <= i_data1;
        end
    end

endmodule

// File: rtl/writeback_merge.sv
// writeback_merge: merges the load and ALU result streams onto one register-file write port.
// Each cycle the oldest buffered result (else the load, else the ALU result) is registered
// onto the write outputs; any other accepted results queue in order in wb_fifo.
// Ports:
//   I_CLOCK, I_RESET          clock, asynchronous active-high reset
//   I_LOCK                    run enable (0 = hold, accept nothing, write nothing)
//   I_Flush                   synchronous clear of FIFO and output register
//   I_Mem*/O_MemReady         load result stream, valid/ready handshake
//   I_ALU*/O_ALUReady         ALU result stream, valid/ready handshake
//   O_WriteBack*              registered register-file write (strobe, index, data, mask)
//   O_Pending                 FIFO occupancy
module writeback_merge
    import wb_pkg::*;
#(
    parameter int unsigned LANES      = LANES_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned IDX_WIDTH  = IDX_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    localparam int unsigned DW        = LANES * DATA_WIDTH,
    localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic                 I_Flush,
    input  logic                 I_MemValid,
    input  logic [IDX_WIDTH-1:0] I_MemDestRegIdx,
    input  logic [DW-1:0]        I_MemData,
    input  logic [LANES-1:0]     I_MemMask,
    output logic                 O_MemReady,
    input  logic                 I_ALUValid,
    input  logic [IDX_WIDTH-1:0] I_ALUDestRegIdx,
    input  logic [DW-1:0]        I_ALUData,
    input  logic [LANES-1:0]     I_ALUMask,
    output logic                 O_ALUReady,
    output logic                 O_WriteBackEnable,
    output logic [IDX_WIDTH-1:0] O_WriteBackRegIdx,
    output logic [DW-1:0]        O_WriteBackData,
    output logic [LANES-1:0]     O_WriteBackMask,
    output logic [CntW-1:0]      O_Pending
);

    localparam int unsigned EntryW = IDX_WIDTH + DW + LANES;

    logic [CntW-1:0]   w_count;
    logic [EntryW-1:0] w_head;
    logic [EntryW-1:0] w_mem_entry;
    logic [EntryW-1:0] w_alu_entry;
    logic              w_mem_take;
    logic              w_alu_take;
    logic              w_head_vld;
    logic              w_wr_en;
    logic [EntryW-1:0] w_wr_entry;
    logic              w_push0;
    logic              w_push1;
    logic [EntryW-1:0] w_push0_entry;
    logic              w_pop;

    logic                 r_wb_en;
    logic [IDX_WIDTH-1:0] r_wb_idx;
    logic [DW-1:0]        r_wb_data;
    logic [LANES-1:0]     r_wb_mask;

    // ALU gets one slot less so that a simultaneous load always still fits.
    assign O_MemReady = I_LOCK && !I_RESET && (w_count < CntW'(DEPTH));
    assign O_ALUReady = I_LOCK && !I_RESET && (w_count < CntW'(DEPTH - 1));

    assign w_mem_entry = {I_MemDestRegIdx, I_MemData, I_MemMask};
    assign w_alu_entry = {I_ALUDestRegIdx, I_ALUData, I_ALUMask};

    // All-zero-mask results are accepted but dropped.
    assign w_mem_take = I_MemValid && O_MemReady && !I_Flush
                        && !mask_is_zero(MASK_MAX'(I_MemMask));
    assign w_alu_take = I_ALUValid && O_ALUReady && !I_Flush
                        && !mask_is_zero(MASK_MAX'(I_ALUMask));
    assign w_head_vld = I_LOCK && !I_Flush && (w_count != '0);

    // Candidate order: FIFO head, load, ALU. First goes out, the rest are pushed in order.
    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_entry    = w_mem_entry;
        w_pop         = 1'b0;
        w_push0       = 1'b0;
        w_push1       = 1'b0;
        w_push0_entry = w_mem_entry;
        if (w_head_vld) begin
            w_wr_en       = 1'b1;
            w_wr_entry    = w_head;
            w_pop         = 1'b1;
            w_push0       = w_mem_take || w_alu_take;
            w_push0_entry = w_mem_take ? w_mem_entry : w_alu_entry;
            w_push1       = w_mem_take && w_alu_take;
        end else if (w_mem_take) begin
            w_wr_en       = 1'b1;
            w_wr_entry    = w_mem_entry;
            w_push0       = w_alu_take;
            w_push0_entry = w_alu_entry;
        end else if (w_alu_take) begin
            w_wr_en    = 1'b1;
            w_wr_entry = w_alu_entry;
        end
    end

    wb_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (I_CLOCK),
        .rst     (I_RESET),
        .i_flush (I_Flush),
        .i_push0 (w_push0),
        .i_data0 (w_push0_entry),
        .i_push1 (w_push1),
        .i_data1 (w_alu_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_wb_en   <= 1'b0;
            r_wb_idx  <= '0;
            r_wb_data <= '0;
            r_wb_mask <= '0;
        end else if (I_Flush) begin
            r_wb_en   <= 1'b0;
            r_wb_idx  <= '0;
            r_wb_data <= '0;
            r_wb_mask <= '0;
        end else if (!I_LOCK) begin
            r_wb_en <= 1'b0;
        end else begin
            r_wb_en <= w_wr_en;
            if (w_wr_en) begin
                {r_wb_idx, r_wb_data, r_wb_mask} <= w_wr_entry;
            end
        end
    end

    assign O_WriteBackEnable = r_wb_en;
    assign O_WriteBackRegIdx = r_wb_idx;
    assign O_WriteBackData   = r_wb_data;
    assign O_WriteBackMask   = r_wb_mask;
    assign O_Pending         = w_count;

endmodule

// File: tb/tb_writeback_merge.sv
// tb_writeback_merge: table-driven directed vectors plus hand-written sequences for
// sustained dual input, flush and asynchronous reset.
module tb_writeback_merge;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_idx;
    logic [63:0] mem_data;
    logic [3:0]  mem_mask;
    logic        mem_ready;
    logic        alu_valid;
    logic [3:0]  alu_idx;
    logic [63:0] alu_data;
    logic [3:0]  alu_mask;
    logic        alu_ready;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [63:0] wb_data;
    logic [3:0]  wb_mask;
    logic [2:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    writeback_merge dut (
        .I_CLOCK           (clk),
        .I_RESET           (rst),
        .I_LOCK            (lock),
        .I_Flush           (flush),
        .I_MemValid        (mem_valid),
        .I_MemDestRegIdx   (mem_idx),
        .I_MemData         (mem_data),
        .I_MemMask         (mem_mask),
        .O_MemReady        (mem_ready),
        .I_ALUValid        (alu_valid),
        .I_ALUDestRegIdx   (alu_idx),
        .I_ALUData         (alu_data),
        .I_ALUMask         (alu_mask),
        .O_ALUReady        (alu_ready),
        .O_WriteBackEnable (wb_en),
        .O_WriteBackRegIdx (wb_idx),
        .O_WriteBackData   (wb_data),
        .O_WriteBackMask   (wb_mask),
        .O_Pending         (pending)
    );

    typedef struct {
        logic        lock;
        logic        mv;
        logic [3:0]  mi;
        logic [15:0] md;
        logic [3:0]  mm;
        logic        av;
        logic [3:0]  ai;
        logic [15:0] ad;
        logic [3:0]  am;
        logic        e_mrdy;
        logic        e_ardy;
        logic        e_en;
        logic [3:0]  e_idx;
        logic [15:0] e_dat;
        logic [3:0]  e_mask;
        logic [2:0]  e_pend;
    } vec_t;

    function automatic vec_t mk(logic lk, logic mv, logic [3:0] mi, logic [15:0] md,
                                logic [3:0] mm, logic av, logic [3:0] ai, logic [15:0] ad,
                                logic [3:0] am, logic erm, logic era, logic ee,
                                logic [3:0] ei, logic [15:0] ed, logic [3:0] em,
                                logic [2:0] ep);
        vec_t v;
        v.lock = lk; v.mv = mv; v.mi = mi; v.md = md; v.mm = mm;
        v.av = av; v.ai = ai; v.ad = ad; v.am = am;
        v.e_mrdy = erm; v.e_ardy = era; v.e_en = ee; v.e_idx = ei;
        v.e_dat = ed; v.e_mask = em; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] mi, input logic [63:0] md,
                         input logic [3:0] mm, input logic av, input logic [3:0] ai,
                         input logic [63:0] ad, input logic [3:0] am);
        mem_valid = mv; mem_idx = mi; mem_data = md; mem_mask = mm;
        alu_valid = av; alu_idx = ai; alu_data = ad; alu_mask = am;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 64'h0, 4'h0, 1'b0, 4'h0, 64'h0, 4'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t      vecs [14];
    wb_entry_t sb [$];
    wb_entry_t e;
    wb_entry_t me;
    wb_entry_t ae;
    int        pend_model;
    logic      saw_stall;
    logic [63:0] rep;

    initial begin
        vecs[0]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 1, 4'h3, 16'h1234, 4'hF,
                      1, 1, 1, 4'h3, 16'h1234, 4'hF, 3'd0);
        vecs[1]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 16'h0000, 4'h0,
                      1, 1, 0, 4'h3, 16'h1234, 4'hF, 3'd0);
        vecs[2]  = mk(1, 1, 4'h2, 16'h0202, 4'hF, 1, 4'h5, 16'h0505, 4'hF,
                      1, 1, 1, 4'h2, 16'h0202, 4'hF, 3'd1);
        vecs[3]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 16'h0000, 4'h0,
                      1, 1, 1, 4'h5, 16'h0505, 4'hF, 3'd0);
        vecs[4]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 16'h0000, 4'h0,
                      1, 1, 0, 4'h5, 16'h0505, 4'hF, 3'd0);
        vecs[5]  = mk(1, 1, 4'h7, 16'hAAAA, 4'hF, 1, 4'h7, 16'h5555, 4'hF,
                      1, 1, 1, 4'h7, 16'hAAAA, 4'hF, 3'd1);
        vecs[6]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 16'h0000, 4'h0,
                      1, 1, 1, 4'h7, 16'h5555, 4'hF, 3'd0);
        vecs[7]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 1, 4'h9, 16'h1111, 4'h0,
                      1, 1, 0, 4'h7, 16'h5555, 4'hF, 3'd0);
        vecs[8]  = mk(1, 0, 4'h0, 16'h0000, 4'h0, 1, 4'h9, 16'h2222, 4'h5,
                      1, 1, 1, 4'h9, 16'h2222, 4'h5, 3'd0);
        vecs[9]  = mk(0, 0, 4'h0, 16'h0000, 4'h0, 1, 4'hA, 16'h3333, 4'hF,
                      0, 0, 0, 4'h9, 16'h2222, 4'h5, 3'd0);
        vecs[10] = mk(1, 1, 4'h1, 16'h0101, 4'h3, 1, 4'h4, 16'h0404, 4'hC,
                      1, 1, 1, 4'h1, 16'h0101, 4'h3, 3'd1);
        vecs[11] = mk(0, 1, 4'h6, 16'h0606, 4'hF, 0, 4'h0, 16'h0000, 4'h0,
                      0, 0, 0, 4'h1, 16'h0101, 4'h3, 3'd1);
        vecs[12] = mk(1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 16'h0000, 4'h0,
                      1, 1, 1, 4'h4, 16'h0404, 4'hC, 3'd0);
        vecs[13] = mk(1, 1, 4'h8, 16'h0808, 4'h0, 1, 4'hB, 16'hBBBB, 4'hF,
                      1, 1, 1, 4'hB, 16'hBBBB, 4'hF, 3'd0);

        // Reset state
        rst = 1'b1; lock = 1'b1; flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", {63'h0, wb_en}, 64'h0);
        chk("rst_idx", {60'h0, wb_idx}, 64'h0);
        chk("rst_data", wb_data, 64'h0);
        chk("rst_mask", {60'h0, wb_mask}, 64'h0);
        chk("rst_pend", {61'h0, pending}, 64'h0);
        chk("rst_mrdy", {63'h0, mem_ready}, 64'h0);
        chk("rst_ardy", {63'h0, alu_ready}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            lock = vecs[i].lock;
            drive(vecs[i].mv, vecs[i].mi, {4{vecs[i].md}}, vecs[i].mm,
                  vecs[i].av, vecs[i].ai, {4{vecs[i].ad}}, vecs[i].am);
            #1;
            chk($sformatf("v%0d_mrdy", i), {63'h0, mem_ready}, {63'h0, vecs[i].e_mrdy});
            chk($sformatf("v%0d_ardy", i), {63'h0, alu_ready}, {63'h0, vecs[i].e_ardy});
            step();
            rep = {4{vecs[i].e_dat}};
            chk($sformatf("v%0d_en", i), {63'h0, wb_en}, {63'h0, vecs[i].e_en});
            chk($sformatf("v%0d_idx", i), {60'h0, wb_idx}, {60'h0, vecs[i].e_idx});
            chk($sformatf("v%0d_data", i), wb_data, rep);
            chk($sformatf("v%0d_mask", i), {60'h0, wb_mask}, {60'h0, vecs[i].e_mask});
            chk($sformatf("v%0d_pend", i), {61'h0, pending}, {61'h0, vecs[i].e_pend});
        end
        lock = 1'b1;
        idle();
        step();

        // Sustained dual input against an in-order scoreboard
        pend_model = 0;
        saw_stall  = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                me.idx  = 4'(k);
                me.data = {4{16'hA000 + 16'(k)}};
                me.mask = 4'hF;
                ae.idx  = 4'(15 - k);
                ae.data = {4{16'hB000 + 16'(k)}};
                ae.mask = 4'hF;
                drive(1'b1, me.idx, me.data, me.mask, 1'b1, ae.idx, ae.data, ae.mask);
            end else begin
                idle();
            end
            #1;
            chk($sformatf("s%0d_mrdy", k), {63'h0, mem_ready}, {63'h0, pend_model < 4});
            chk($sformatf("s%0d_ardy", k), {63'h0, alu_ready}, {63'h0, pend_model < 3});
            if (k < 16) begin
                if (pend_model == 3) saw_stall = 1'b1;
                if (pend_model < 4) sb.push_back(me);
                if (pend_model < 3) sb.push_back(ae);
            end
            step();
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("s%0d_en", k), {63'h0, wb_en}, 64'h1);
                chk($sformatf("s%0d_idx", k), {60'h0, wb_idx}, {60'h0, e.idx});
                chk($sformatf("s%0d_data", k), wb_data, e.data);
            end else begin
                chk($sformatf("s%0d_en", k), {63'h0, wb_en}, 64'h0);
            end
            pend_model = sb.size();
            chk($sformatf("s%0d_pend", k), {61'h0, pending}, 64'(pend_model));
        end
        chk("alu_stall_seen", {63'h0, saw_stall}, 64'h1);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        // Fill to 3, then flush with inputs present
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h1, {4{16'h1111}}, 4'hF, 1'b1, 4'h2, {4{16'h2222}}, 4'hF);
            step();
        end
        chk("fill1_pend", {61'h0, pending}, 64'h3);
        flush = 1'b1;
        step();
        chk("flush_en", {63'h0, wb_en}, 64'h0);
        chk("flush_pend", {61'h0, pending}, 64'h0);
        flush = 1'b0;
        idle();
        step();
        chk("postflush_en", {63'h0, wb_en}, 64'h0);
        chk("postflush_pend", {61'h0, pending}, 64'h0);

        // Fill to 3 again, then asynchronous reset between edges
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h3, {4{16'h3333}}, 4'hF, 1'b1, 4'h4, {4{16'h4444}}, 4'hF);
            step();
        end
        chk("fill2_pend", {61'h0, pending}, 64'h3);
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_en", {63'h0, wb_en}, 64'h0);
        chk("arst_idx", {60'h0, wb_idx}, 64'h0);
        chk("arst_data", wb_data, 64'h0);
        chk("arst_mask", {60'h0, wb_mask}, 64'h0);
        chk("arst_pend", {61'h0, pending}, 64'h0);
        chk("arst_mrdy", {63'h0, mem_ready}, 64'h0);
        chk("arst_ardy", {63'h0, alu_ready}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("postrst_en", {63'h0, wb_en}, 64'h0);
        chk("postrst_pend", {61'h0, pending}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
